// File: rtl/cache_refill_responder_pkg.sv
// Shared widths, line geometry and responder FSM state encoding for the cache refill path.
package cache_refill_responder_pkg;

  localparam int CACHE_ADDR_WIDTH  = 8;
  localparam int CACHE_DATA_WIDTH  = 32;
  localparam int SET_BITS          = 4;
  localparam int BLOCK_OFFSET_BITS = 2;
  localparam int BYTE_OFFSET_BITS  = 2;
  localparam int LINE_WORDS        = 1 << BLOCK_OFFSET_BITS;
  localparam int MEM_LATENCY_DEF   = 2;

  typedef enum logic [2:0] {
    IDLE,
    WAIT,
    READ_BURST,
    WRITE_BURST,
    WRITE_ACK
  } resp_state_e;

endpackage

// File: rtl/cache_refill_responder_if.sv
// Request, write-back and refill channels between the cache miss path and the responder.
interface cache_refill_responder_if #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_write;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic                  wdata_valid;
  logic                  wdata_ready;
  logic [DATA_WIDTH-1:0] wdata;
  logic                  rdata_valid;
  logic                  rdata_ready;
  logic [DATA_WIDTH-1:0] rdata;
  logic                  rdata_last;
  logic                  wr_done;

  modport master (
    output req_valid, req_write, req_addr, wdata_valid, wdata, rdata_ready,
    input  req_ready, wdata_ready, rdata_valid, rdata, rdata_last, wr_done
  );

  modport slave (
    input  req_valid, req_write, req_addr, wdata_valid, wdata, rdata_ready,
    output req_ready, wdata_ready, rdata_valid, rdata, rdata_last, wr_done
  );
endinterface

// File: rtl/cache_refill_responder_refill_word_ram.sv
// Word-addressed backing store: one synchronous write port, one asynchronous read port, no reset.
module refill_word_ram #(
  parameter int AW = 6,
  parameter int DW = 32
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [DW-1:0] rdata_o
);

  logic [DW-1:0] mem [2**AW];

  always_ff @(posedge clk_i) begin
    if (we_i) mem[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem[raddr_i];

endmodule

// File: rtl/cache_refill_responder.sv
// Memory-side responder serving line refills and accepting write-backs as fixed-length bursts.
// Optional REFILL_CRITICAL_WORD_FIRST_EN: refills start at the requested word and wrap.
//   state       | meaning
//   IDLE        | ready for a new line request
//   WAIT        | memory latency countdown before the first refill beat
//   READ_BURST  | presenting refill beats
//   WRITE_BURST | collecting write-back beats
//   WRITE_ACK   | one-cycle write-back completion pulse
module cache_refill_responder
  import cache_refill_responder_pkg::*;
#(
  parameter int ADDR_WIDTH  = CACHE_ADDR_WIDTH,
  parameter int DATA_WIDTH  = CACHE_DATA_WIDTH,
  parameter int LINE_WORDS  = cache_refill_responder_pkg::LINE_WORDS,
  parameter int MEM_LATENCY = MEM_LATENCY_DEF
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  cache_refill_responder_if.slave  bus
);

  localparam int BO      = $clog2(LINE_WORDS);
  localparam int WORD_AW = ADDR_WIDTH - BYTE_OFFSET_BITS;
  localparam int LINE_AW = WORD_AW - BO;
  localparam int LAT_W   = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;

  resp_state_e           state;
  logic [BO-1:0]         beat_cnt;
  logic [BO-1:0]         start_q;
  logic [LINE_AW-1:0]    line_q;
  logic [LAT_W-1:0]      lat_cnt;
  logic                  req_ready_q;
  logic                  wdata_ready_q;
  logic                  rvalid_q;
  logic                  rlast_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic                  wr_done_q;

  logic [BO-1:0]         req_word;
  logic [LINE_AW-1:0]    rd_line;
  logic [BO-1:0]         rd_off;
  logic [DATA_WIDTH-1:0] rd_word;
  logic                  wr_en;
  logic                  rd_hs;
  logic [BYTE_OFFSET_BITS-1:0] unused_byte_off;

`ifdef REFILL_CRITICAL_WORD_FIRST_EN
  assign req_word = bus.req_addr[BYTE_OFFSET_BITS +: BO];
`else
  logic [BO-1:0] unused_req_word;
  assign unused_req_word = bus.req_addr[BYTE_OFFSET_BITS +: BO];
  assign req_word        = '0;
`endif
  assign unused_byte_off = bus.req_addr[BYTE_OFFSET_BITS-1:0];

  // In IDLE the read port already points at the requested line so a zero-latency
  // build can load the first beat on the accepting edge.
  always_comb begin
    rd_line = line_q;
    rd_off  = start_q;
    if (state == IDLE) begin
      rd_line = bus.req_addr[ADDR_WIDTH-1 -: LINE_AW];
      rd_off  = req_word;
    end else if (state == READ_BURST) begin
      rd_off = start_q + beat_cnt + BO'(1);
    end
  end

  assign wr_en = wdata_ready_q && bus.wdata_valid;
  assign rd_hs = rvalid_q && bus.rdata_ready;

  refill_word_ram #(.AW(WORD_AW), .DW(DATA_WIDTH)) u_ram (
    .clk_i   (clk_i),
    .we_i    (wr_en),
    .waddr_i ({line_q, beat_cnt}),
    .wdata_i (bus.wdata),
    .raddr_i ({rd_line, rd_off}),
    .rdata_o (rd_word)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state         <= IDLE;
      beat_cnt      <= '0;
      start_q       <= '0;
      line_q        <= '0;
      lat_cnt       <= '0;
      req_ready_q   <= 1'b1;
      wdata_ready_q <= 1'b0;
      rvalid_q      <= 1'b0;
      rlast_q       <= 1'b0;
      rdata_q       <= '0;
      wr_done_q     <= 1'b0;
    end else begin
      wr_done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.req_valid) begin
            req_ready_q <= 1'b0;
            line_q      <= bus.req_addr[ADDR_WIDTH-1 -: LINE_AW];
            start_q     <= req_word;
            beat_cnt    <= '0;
            if (bus.req_write) begin
              state         <= WRITE_BURST;
              wdata_ready_q <= 1'b1;
            end else if (MEM_LATENCY == 0) begin
              state    <= READ_BURST;
              rvalid_q <= 1'b1;
              rdata_q  <= rd_word;
              rlast_q  <= 1'b0;
            end else begin
              state   <= WAIT;
              lat_cnt <= LAT_W'(MEM_LATENCY - 1);
            end
          end
        end
        WAIT: begin
          if (lat_cnt == '0) begin
            state    <= READ_BURST;
            rvalid_q <= 1'b1;
            rdata_q  <= rd_word;
            rlast_q  <= 1'b0;
          end else begin
            lat_cnt <= lat_cnt - 1'b1;
          end
        end
        READ_BURST: begin
          if (rd_hs) begin
            if (rlast_q) begin
              state       <= IDLE;
              rvalid_q    <= 1'b0;
              rlast_q     <= 1'b0;
              req_ready_q <= 1'b1;
            end else begin
              beat_cnt <= beat_cnt + 1'b1;
              rdata_q  <= rd_word;
              rlast_q  <= (beat_cnt == BO'(LINE_WORDS - 2));
            end
          end
        end
        WRITE_BURST: begin
          if (wr_en) begin
            beat_cnt <= beat_cnt + 1'b1;
            if (beat_cnt == BO'(LINE_WORDS - 1)) begin
              state         <= WRITE_ACK;
              wdata_ready_q <= 1'b0;
              wr_done_q     <= 1'b1;
            end
          end
        end
        WRITE_ACK: begin
          state       <= IDLE;
          req_ready_q <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.req_ready   = req_ready_q;
  assign bus.wdata_ready = wdata_ready_q;
  assign bus.rdata_valid = rvalid_q;
  assign bus.rdata_last  = rlast_q;
  assign bus.rdata       = rdata_q;
  assign bus.wr_done     = wr_done_q;

endmodule
